// File: rtl/mux_scan_sequencer.sv
// mux_scan_sequencer: steps sel over enabled channels of an 8:1 mux,
// holds each SETTLE cycles, samples y, then publishes the 8-bit result.
//
// Ports:
//   clk, rst     clock, synchronous active-high reset
//   start        scan request, taken only when idle
//   ch_mask[7:0] enabled channels, latched when start is taken
//   sel[2:0]     channel select to the external mux
//   y            external mux output
//   busy         high while a scan (including its done cycle) runs
//   done         one-cycle completion pulse
//   sample[7:0]  result of the last completed scan
//   parity       XOR of sample (only with MUX_SCAN_PARITY_EN defined)
//
// sample and parity take their new value on the edge that enters
// the done cycle, so both are valid while done is high.
module mux_scan_sequencer #(
  parameter int unsigned SETTLE = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] ch_mask,
  output logic [2:0] sel,
  input  logic       y,
  output logic       busy,
  output logic       done,
  output logic [7:0] sample
`ifdef MUX_SCAN_PARITY_EN
  ,
  output logic       parity
`endif
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SETTLE = 2'd1;
  localparam logic [1:0] S_DONE   = 2'd2;

  localparam logic [3:0] CNT_LAST = 4'(SETTLE - 1);

  logic [1:0] state;
  logic [3:0] cnt;
  logic [7:0] mask;
  logic [7:0] shadow;
  logic [7:0] shadow_upd;
  logic [2:0] first_sel;
  logic [2:0] nxt_sel;
  logic       has_nxt;

  // Lowest enabled channel of the incoming mask.
  always_comb begin
    first_sel = '0;
    for (int i = 7; i >= 0; i--) begin
      if (ch_mask[i]) first_sel = 3'(i);
    end
  end

  // Next enabled channel strictly above sel; none means scan ends.
  always_comb begin
    has_nxt = 1'b0;
    nxt_sel = sel;
    for (int i = 7; i >= 0; i--) begin
      if (mask[i] && (3'(i) > sel)) begin
        has_nxt = 1'b1;
        nxt_sel = 3'(i);
      end
    end
  end

  // Shadow with the current channel's y merged in.
  always_comb begin
    shadow_upd      = shadow;
    shadow_upd[sel] = y;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_IDLE;
      sel    <= '0;
      cnt    <= '0;
      mask   <= '0;
      shadow <= '0;
      sample <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (start) begin
            mask   <= ch_mask;
            shadow <= '0;
            cnt    <= '0;
            if (ch_mask != 8'h00) begin
              state <= S_SETTLE;
              sel   <= first_sel;
            end else begin
              state  <= S_DONE;
              sample <= '0;
            end
          end
        end
        S_SETTLE: begin
          if (cnt == CNT_LAST) begin
            cnt    <= '0;
            shadow <= shadow_upd;
            if (has_nxt) begin
              sel <= nxt_sel;
            end else begin
              state  <= S_DONE;
              sample <= shadow_upd;
            end
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  assign busy = (state != S_IDLE);
  assign done = (state == S_DONE);

`ifdef MUX_SCAN_PARITY_EN
  assign parity = ^sample;
`endif

endmodule

// File: doc/mux_scan_sequencer.md
MUX_SCAN_SEQUENCER -- requirements
Module: mux_scan_sequencer

Interface
REQ-001 SHALL provide parameter SETTLE, default 2, the number of cycles sel is held per channel before y is sampled (legal range 1..15).
REQ-002 SHALL provide port clk  input  1  the single clock; all state changes on its rising edge.
REQ-003 SHALL provide port rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL provide port start  input  1  scan request, sampled in IDLE only.
REQ-005 SHALL provide port ch_mask  input  8  channel enable mask, captured when start is accepted.
REQ-006 SHALL provide port sel  output  3  channel select driven to the downstream 8:1 mux.
REQ-007 SHALL provide port y  input  1  mux output returned from the 8:1 mux.
REQ-008 SHALL provide port busy  output  1  high whenever the state is not IDLE.
REQ-009 SHALL provide port done  output  1  one-cycle pulse marking scan completion.
REQ-010 SHALL provide port sample  output  8  result of the last completed scan; bit i holds y captured with sel==i.

Function
REQ-011 SHALL implement the FSM states IDLE, SETTLE and DONE.
REQ-012 In IDLE with start=1, SHALL latch ch_mask; next state is SETTLE with sel = lowest set mask bit, or DONE if the mask is 0.
REQ-013 In SETTLE, SHALL hold sel stable for exactly SETTLE cycles and sample y into shadow bit[sel] at the edge ending the last of those cycles.
REQ-014 After sampling, SHALL move sel to the next higher set mask bit and stay in SETTLE; after the highest set bit it SHALL go to DONE; there is no wrap-around past channel 7.
REQ-015 In DONE, SHALL assert done for one cycle, load sample from shadow on that edge, and return to IDLE.
REQ-016 Shadow bits of disabled channels SHALL be 0; shadow SHALL clear when start is accepted.
REQ-017 Latency: for N enabled channels, busy SHALL stay high for N*SETTLE+1 cycles, and done SHALL be the last of them; for N=0 this is 1 cycle.
REQ-018 start SHALL be ignored while busy; ch_mask changes during a scan SHALL have no effect.
REQ-019 start held high SHALL begin a new scan on the cycle after DONE (back-to-back scans with one IDLE cycle).
REQ-020 sel SHALL hold its last value in IDLE and DONE.
REQ-021 sample SHALL change only in the DONE cycle.

Reset
REQ-022 When rst=1 at a rising edge, SHALL set state IDLE, sel=0, busy=0, done=0, sample=0, shadow=0 and SETTLE counter=0.
REQ-023 rst SHALL take priority over start and over any in-progress scan; a scan aborted mid-operation SHALL NOT pulse done or update sample.

Configuration
REQ-024 With MUX_SCAN_PARITY_EN defined, SHALL add output parity (1 bit) = XOR of the 8 sample bits.
REQ-025 parity SHALL be reset to 0 and updated in the same cycle as sample.
REQ-026 Without MUX_SCAN_PARITY_EN, the parity port and its logic SHALL be absent; all other behaviour is identical.

Verification
REQ-027 SETTLE=2, ch_mask=8'hFF, mux data 8'hA5, start pulse -> sel steps 0..7 with 2 cycles each, done in the 17th cycle after acceptance, sample=8'hA5.
REQ-028 ch_mask=8'h81, mux data 8'hFF -> sel visits only 0 then 7, busy high for 5 cycles, sample=8'h81.
REQ-029 ch_mask=8'h00, start -> busy and done high for 1 cycle, sample=8'h00, sel unchanged.
REQ-030 start pulsed again mid-scan and ch_mask changed to 8'h0F mid-scan -> both ignored, result matches the original mask, exactly one done pulse.
REQ-031 rst asserted in the 5th cycle of an 8'hFF scan -> next cycle busy=0, sel=0, sample=0, no done pulse; a fresh start then completes normally.
REQ-032 MUX_SCAN_PARITY_EN defined, data 8'h07, mask 8'hFF -> parity=1 in the done cycle; data 8'h03 -> parity=0.
